// File: rtl/inst_rom_responder.sv
// inst_rom_responder: instruction-side memory responder for the IF-stage fetch
// interface. Holds a word-addressed instruction store, returns the addressed
// word after a configurable number of wait states, requests a PC stall while a
// fetch is outstanding, flags misaligned/out-of-range fetches and drops an
// in-flight fetch on a branch flush.
module inst_rom_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              stall_req,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              fetch_exc
);

  localparam int IDX_W = $clog2(DEPTH);
  // First byte address past the end of the store, one bit wider than an
  // address so the comparison cannot wrap.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 2;

  // The wait counter is 4 bits wide; larger wait counts cannot be represented.
  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("inst_rom_responder: WAIT_CYCLES must be in 0..15");
    end
    if ((DEPTH < 2) || ((1 << IDX_W) != DEPTH)) begin : g_bad_depth
      $error("inst_rom_responder: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   inst_reg;
  logic [ADDR_W-1:0]   inst_pc_reg;
  logic                inst_valid_reg;
  logic                fetch_exc_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                load_resp;
  logic [ADDR_W-1:0]   resp_addr;
  logic                resp_fault;
  logic [IDX_W-1:0]    resp_idx;
  logic                wr_ok;

  // A fetch faults when it is not word aligned or falls past the store.
  function automatic logic is_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  assign accept = (state_reg != S_WAIT) && rom_en && !flush;

  // With no wait states the response is built from the live address at the
  // accept edge; otherwise from the address latched when the fetch was taken.
  assign resp_addr  = (WAIT_CYCLES == 0) ? addr : addr_reg;
  assign resp_fault = is_fault(resp_addr);
  assign resp_idx   = resp_addr[IDX_W+1:2];

  // The response registers load at the edge that enters RESP.
  assign load_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_reg == S_WAIT) && !flush && (cnt_reg == 4'd1));

  assign wr_ok = prog_we && !is_fault(prog_addr);

  // Program-load port; the fetch read below sees the old word on a same-edge write.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[prog_addr[IDX_W+1:2]] <= prog_data;
    end
  end

  // Fetch sequencer: accept, count down wait states, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_reg <= addr;
            if (WAIT_CYCLES == 0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= 4'(WAIT_CYCLES);
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd1) begin
            state_reg <= S_RESP;
            cnt_reg   <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

  // Response registers: inst/inst_pc/fetch_exc hold between fetches, valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      fetch_exc_reg  <= 1'b0;
    end else begin
      inst_valid_reg <= load_resp;
      if (load_resp) begin
        inst_reg      <= resp_fault ? NOP_WORD : mem[resp_idx];
        inst_pc_reg   <= resp_addr;
        fetch_exc_reg <= resp_fault;
      end
    end
  end

  // PC stall while a fetch is outstanding; released in the last wait cycle
  // and whenever a flush is present.
  always_comb begin
    stall_req = 1'b0;
    if (WAIT_CYCLES != 0) begin
      if (state_reg == S_WAIT) begin
        stall_req = !flush && (cnt_reg != 4'd1);
      end else begin
        stall_req = accept;
      end
    end
  end

  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;
  assign fetch_exc  = fetch_exc_reg;

endmodule
